ps2_key_tracker: RTL
====================

Name: ps2_key_tracker

Overview:
Sits directly downstream of the PS/2 byte receiver and upstream of the scan-code-to-note mapper. It consumes raw PS/2 set-2 bytes and decodes the E0 extended prefix and the F0 break prefix. It suppresses typematic repeats and presents a clean held-key level plus one-cycle press and release pulses, so the note stage sounds only while a key is physically held. Last-key-wins policy: exactly one tracked key.

Parameters:
TIMEOUT_CYCLES, 2000000, cycles a prefix state may wait for its next byte before aborting to IDLE (20 ms at 100 MHz); minimum 2.

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high reset
scan_code  input  8  byte from the PS/2 receiver; valid when scan_code_ready rises
scan_code_ready  input  1  byte-valid from the receiver; may be a pulse or a level; rising edge is used
key_code  output  8  set-2 code of the tracked key; holds its value after release
key_extended  output  1  1 = tracked key was E0-prefixed
key_held  output  1  1 while the tracked key is down
press_pulse  output  1  one-cycle pulse when a new key becomes tracked
release_pulse  output  1  one-cycle pulse when the tracked key is released

Behaviour:
- Reset (async, active-high): state=IDLE; timer=0; key_code=0x00; key_extended=0; key_held=0; both pulses=0; ready-edge register=0.
- Byte event: scan_code_ready=1 while the registered previous ready=0. A level held high counts once. scan_code is sampled on the same edge.
- All outputs are registered. Outputs reflect a byte event on the clock edge that samples it, so there is 1 cycle of latency from the strobe.
- Pulses are high for exactly one cycle and are never both high in the same cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - 0x00, 0xAA, 0xFA, 0xFE, 0xFF: ignored, stay IDLE.
    - Any other byte B: make(ext=0, B).
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT and restart the timer.
    - Other B: make(1, B) -> IDLE.
  - BRK:
    - E0 -> EXT_BRK.
    - F0 -> stay and restart the timer.
    - Other B: break(0, B) -> IDLE.
  - EXT_BRK:
    - E0 or F0 -> stay and restart the timer.
    - Other B: break(1, B) -> IDLE.
- make(x, B):
  - If key_held=1 and {key_extended, key_code}=={x, B}, it is a typematic repeat: no output change, no pulse.
  - Otherwise: key_code<=B, key_extended<=x, key_held<=1, press_pulse<=1. This includes replacing a different held key, which produces no release_pulse for the old key.
- break(x, B):
  - If key_held=1 and {x, B} matches: key_held<=0, release_pulse<=1.
  - Otherwise ignored (stale break of a replaced key); key_code and key_extended are unchanged.
- Timeout:
  - In EXT, BRK or EXT_BRK the timer increments each cycle without a byte event.
  - When timer==TIMEOUT_CYCLES-1, next state is IDLE and the timer clears. No output change and no pulse.
  - The timer is 0 in IDLE and clears on every byte event.
  - The timer width is clog2(TIMEOUT_CYCLES).
- Simultaneous events: a byte event on the same cycle the timeout would fire takes priority and is decoded in the current state.
- Reset mid-sequence (for example after E0 F0): returns to IDLE with key_held=0. The next data byte is treated as a make.

Test Plan:
- Reset, then bytes 0x1C -> key_code=0x1C, key_extended=0, key_held=1, press_pulse for 1 cycle one edge after the strobe. Then 0x1C 0x1C 0x1C -> no pulse and outputs stable. Then F0 1C -> key_held=0, one release_pulse, key_code stays 0x1C.
- E0 75 -> key_code=0x75, key_extended=1, press_pulse. Then F0 75 (non-extended break) -> ignored, key_held stays 1. Then E0 F0 75 -> release_pulse, key_held=0.
- 1C held, then 1B -> key_code=0x1B, press_pulse, no release_pulse. Then F0 1C -> ignored. Then F0 1B -> release.
- AA, FA, 00 in IDLE -> no output change. scan_code_ready held high for 10 cycles with 0x23 -> exactly one press_pulse.
- TIMEOUT_CYCLES=8: E0, then idle for 8 cycles, then 0x1C -> non-extended make of 0x1C. Separately, byte arrival on the timeout cycle -> decoded as extended.
- Assert reset after F0, mid-sequence -> all outputs 0 asynchronously. After release, 0x2B -> make 0x2B with press_pulse.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: byte-in / key-state-out bundle between the PS/2 receiver, key tracker and note mapper
interface ps2_key_tracker_if;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_held;
  logic       press_pulse;
  logic       release_pulse;
  modport master (
    output scan_code, scan_code_ready,
    input  key_code, key_extended, key_held, press_pulse, release_pulse
  );
  modport slave (
    input  scan_code, scan_code_ready,
    output key_code, key_extended, key_held, press_pulse, release_pulse
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 set-2 E0/F0 prefixes into a single last-key-wins held level with press/release pulses
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic             clk,
  input logic             reset,
  ps2_key_tracker_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q;
  logic          rdy_q;
  logic [7:0]    code_q;
  logic          ext_q, held_q, press_q, rel_q;
  logic          ev, is_e0, is_f0, is_ign, pfx, x, mk, brk, hit, tmo;
  // byte-event detection, make/break classification and prefix-state transitions
  always_comb begin
    ev = bus.scan_code_ready && !rdy_q;
    is_e0 = bus.scan_code == 8'hE0;
    is_f0 = bus.scan_code == 8'hF0;
    is_ign = bus.scan_code inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
    pfx = is_e0 || is_f0;
    x = state_q == EXT || state_q == EXT_BRK;
    mk = ev && !pfx && (state_q == EXT || (state_q == IDLE && !is_ign));
    brk = ev && !pfx && (state_q == BRK || state_q == EXT_BRK);
    hit = held_q && {ext_q, code_q} == {x, bus.scan_code};
    tmo = state_q != IDLE && tmr_q == TW'(TIMEOUT_CYCLES - 1);
    state_d = !ev ? (tmo ? IDLE : state_q) :
              !pfx ? IDLE :
              state_q == IDLE ? (is_e0 ? EXT : BRK) :
              state_q == EXT ? (is_f0 ? EXT_BRK : EXT) :
              state_q == BRK ? (is_e0 ? EXT_BRK : BRK) : EXT_BRK;
  end
  // FSM, prefix timeout and registered key outputs; a repeat make or a stale break leaves everything unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q <= '0;
      rdy_q <= 1'b0;
      code_q <= 8'h00;
      ext_q <= 1'b0;
      held_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      rdy_q <= bus.scan_code_ready;
      state_q <= state_d;
      tmr_q <= (ev || tmo || state_q == IDLE) ? '0 : tmr_q + TW'(1);
      press_q <= mk && !hit;
      rel_q <= brk && hit;
      if (mk && !hit) begin
        code_q <= bus.scan_code;
        ext_q <= x;
        held_q <= 1'b1;
      end else if (brk && hit) begin
        held_q <= 1'b0;
      end
    end
  end
  assign bus.key_code = code_q;
  assign bus.key_extended = ext_q;
  assign bus.key_held = held_q;
  assign bus.press_pulse = press_q;
  assign bus.release_pulse = rel_q;
endmodule
